uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_trans transmitter between NUM_REQ byte sources. Round-robin
//  pick, valid/ready capture per requester, one-cycle TX_DV launch, TX_BYTE held
//  stable for the whole frame, and re-arm only once the transmitter is back in IDLE.
// PARAMETERS
//  NUM_REQ        4      number of requesters (>=2)
//  TIMEOUT_CYCLES 2387   WAIT_DONE watchdog limit (11*217); used only with UART_ARB_TIMEOUT_EN
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous, active-high reset
//  REQ_VALID    in   NUM_REQ    per-requester byte valid; held until REQ_READY
//  REQ_BYTE     in   8*NUM_REQ  per-requester byte; slice i = [8*i+7:8*i]
//  REQ_READY    out  NUM_REQ    one-hot accept; transfer on edge with VALID&READY
//  GRANT_ID     out  $clog2(NUM_REQ)  index of the requester owning the current frame
//  BUSY         out  1          high from accept until return to IDLE
//  TX_DV        out  1          to uart_trans; one-cycle launch pulse
//  TX_BYTE      out  8          to uart_trans; stable from LAUNCH until TX_Done
//  TX_Active    in   1          from uart_trans
//  TX_Done      in   1          from uart_trans; one-cycle end-of-stop-bit pulse
//  TIMEOUT_ERR  out  1          one-cycle watchdog pulse (0 when macro off)
// BEHAVIOUR
//  Reset: state<=GAP; TX_DV=0, TX_BYTE=8'h00, GRANT_ID=0, rr_ptr=0, BUSY=0,
//   TIMEOUT_ERR=0, REQ_READY=0. uart_trans has no reset; a frame may still be running.
//  States: IDLE, LAUNCH, WAIT_DONE, GAP.
//  IDLE: if TX_Done=1 -> GAP. Else if TX_Active=0 and |REQ_VALID: winner = first
//   valid index at or after rr_ptr (wrapping NUM_REQ-1 -> 0); REQ_READY[winner]=1
//   combinationally this cycle only; on the edge: TX_BYTE<=REQ_BYTE[winner],
//   GRANT_ID<=winner, rr_ptr<=winner+1 (mod NUM_REQ), BUSY<=1, -> LAUNCH.
//   TX_Active=1 in IDLE blocks all grants (post-reset orphan frame).
//  LAUNCH: TX_DV=1 for exactly this cycle -> WAIT_DONE. REQ_READY all 0.
//  WAIT_DONE: TX_DV=0; TX_BYTE/GRANT_ID frozen; on TX_Done=1 -> GAP.
//  GAP: one guard cycle covering uart_trans CLEAN_UP (a TX_DV there is lost);
//   BUSY<=0 -> IDLE. Min spacing TX_Done -> next TX_DV = 3 cycles.
//  Latency: accept edge -> TX_DV high next cycle; request seen in IDLE is accepted same cycle.
//  Simultaneous: several valids -> only one READY; losers keep VALID, no data loss.
//  REQ_VALID dropping before READY is legal (no capture). Stray TX_Done outside
//   WAIT_DONE ignored except in IDLE (-> GAP).
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: counter cleared in LAUNCH, +1 per WAIT_DONE cycle;
//   at TIMEOUT_CYCLES-1 without TX_Done: TIMEOUT_ERR=1 one cycle, -> GAP; byte dropped.
//   Width $clog2(TIMEOUT_CYCLES+1); saturation not needed (exit on hit).
//  Not defined: no counter, WAIT_DONE waits indefinitely, TIMEOUT_ERR tied 0.
// STRUCTURE
//  uart_pkg: arb_state_t enum {IDLE,LAUNCH,WAIT_DONE,GAP}; UART_CLKS_PER_BIT=217;
//   UART_FRAME_BITS=10; UART_BYTE_W=8.
//  Sub-module uart_rr_pick: combinational (REQ_VALID, rr_ptr) -> winner, any_valid.
//  Top: FSM, byte/grant registers, watchdog under `ifdef.
// TESTING  (bench: uart_trans + arbiter, CLKS_PER_BITS=8, NUM_REQ=4)
//  1 Req0 VALID, byte 8'hA5 -> READY[0] 1 cycle; TX_DV next cycle; TX_BYTE=A5 until
//    TX_Done; serial decodes A5 LSB first; BUSY low 1 cycle after GAP.
//  2 All 4 valid, bytes 11,22,33,44 -> served 0,1,2,3, each TX_DV >=3 cycles after
//    previous TX_Done; repeat -> order restarts at 0.
//  3 Req1, Req2 permanently valid -> grants alternate 1,2,1,2; Req0/3 never READY.
//  4 rst for 2 cycles mid DATA_BITS -> outputs at reset values; no TX_DV until
//    TX_Active falls plus GAP; next grant goes to lowest valid index from 0.
//  5 Macro on, stub holds TX_Done=0, TIMEOUT_CYCLES=50 -> TIMEOUT_ERR pulse 50 cycles
//    after LAUNCH, GAP, IDLE; macro off -> no pulse, BUSY stays 1.
//  6 Checker over all tests: TX_DV never high while TX_Active=1 or in cycle after TX_Done;
//    TX_BYTE never changes between TX_DV and TX_Done.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and UART framing constants for the uart_tx_arbiter slice.
package uart_tx_arbiter_pkg;

   localparam int unsigned UART_CLKS_PER_BIT = 217;
   localparam int unsigned UART_FRAME_BITS   = 10;
   localparam int unsigned UART_BYTE_W       = 8;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE,
      GAP
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side valid/ready byte bus; master = byte sources, slave = arbiter.
interface uart_tx_arbiter_if
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) ();

   logic [NUM_REQ-1:0]             REQ_VALID;
   logic [UART_BYTE_W*NUM_REQ-1:0] REQ_BYTE;
   logic [NUM_REQ-1:0]             REQ_READY;

   modport master (output REQ_VALID, output REQ_BYTE, input REQ_READY);
   modport slave  (input REQ_VALID, input REQ_BYTE, output REQ_READY);

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid index at or after the pointer.
module uart_rr_pick #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         i_valid,
   input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
   output logic [$clog2(NUM_REQ)-1:0] o_winner,
   output logic                       o_any_valid
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   int unsigned w_idx;

   // Scan offsets from farthest to nearest so the nearest valid index wins.
   always_comb begin
      o_winner    = '0;
      w_idx       = 0;
      o_any_valid = |i_valid;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = 32'(i_ptr) + (NUM_REQ - 1 - k);
         if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
         end
         if (i_valid[IDX_W'(w_idx)]) begin
            o_winner = IDX_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_trans transmitter between NUM_REQ sources.
// Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = (UART_FRAME_BITS + 1) * UART_CLKS_PER_BIT
) (
   input  logic                       clk,
   input  logic                       rst,
   uart_tx_arbiter_if.slave           bus,
   output logic [$clog2(NUM_REQ)-1:0] GRANT_ID,
   output logic                       BUSY,
   output logic                       TX_DV,
   output logic [UART_BYTE_W-1:0]     TX_BYTE,
   input  logic                       TX_Active,
   input  logic                       TX_Done,
   output logic                       TIMEOUT_ERR
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_t             r_state;
   arb_state_t             w_next;
   logic [IDX_W-1:0]       r_ptr;
   logic [IDX_W-1:0]       r_grant;
   logic [IDX_W-1:0]       w_winner;
   logic                   w_any_valid;
   logic                   w_accept;
   logic                   w_timeout;
   logic [NUM_REQ-1:0]     w_ready;
   logic                   r_tx_dv;
   logic                   r_busy;
   logic [UART_BYTE_W-1:0] r_tx_byte;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_valid     (bus.REQ_VALID),
      .i_ptr       (r_ptr),
      .o_winner    (w_winner),
      .o_any_valid (w_any_valid)
   );

   // State register; reset parks in GAP so a guard cycle precedes the first grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= GAP;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state, accept decode and one-hot ready; an active orphan frame blocks grants.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_ready  = '0;
      case (r_state)
         IDLE: begin
            if (TX_Done) begin
               w_next = GAP;
            end else if (!TX_Active && w_any_valid && !rst) begin
               w_accept          = 1'b1;
               w_ready[w_winner] = 1'b1;
               w_next            = LAUNCH;
            end
         end
         LAUNCH:    w_next = WAIT_DONE;
         WAIT_DONE: if (TX_Done || w_timeout) w_next = GAP;
         GAP:       w_next = IDLE;
         default:   w_next = GAP;
      endcase
   end

   // Capture byte and grant on accept, advance pointer, launch pulse and busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_dv   <= 1'b0;
         r_tx_byte <= '0;
         r_grant   <= '0;
         r_ptr     <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_tx_dv <= w_accept;
         if (w_accept) begin
            r_tx_byte <= bus.REQ_BYTE[UART_BYTE_W*32'(w_winner) +: UART_BYTE_W];
            r_grant   <= w_winner;
            r_ptr     <= (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + IDX_W'(1);
            r_busy    <= 1'b1;
         end else if (r_state == GAP) begin
            r_busy <= 1'b0;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_to_cnt;

   // Watchdog: cleared in LAUNCH, counts WAIT_DONE cycles; the hit abandons the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_to_cnt <= '0;
      end else if (r_state == LAUNCH) begin
         r_to_cnt <= '0;
      end else if (r_state == WAIT_DONE) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   assign w_timeout = (r_state == WAIT_DONE) && !TX_Done && !rst &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   assign bus.REQ_READY = w_ready;
   assign GRANT_ID      = r_grant;
   assign BUSY          = r_busy;
   assign TX_DV         = r_tx_dv;
   assign TX_BYTE       = r_tx_byte;
   assign TIMEOUT_ERR   = w_timeout;

endmodule
